icache_fetch: RTL and testbench

//  Parametrised instruction-fetch stage with a direct-mapped I-cache and a registered miss FSM.

---
 rtl/icache_fetch_pkg.sv | 20 ++
 rtl/icache_fetch_array.sv | 57 +++++
 rtl/icache_fetch.sv | 188 ++++++++++++++++++
 tb/tb_icache_fetch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_fetch_pkg.sv
// Shared constants, FSM encoding and default geometry for the fetch stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package icache_fetch_pkg;

  localparam int AddrLen       = 32;
  localparam int InstLen       = 32;
  localparam int DefaultIndexW = 7;

  localparam logic [InstLen-1:0] ZERO_WORD = '0;
  localparam logic               True      = 1'b1;
  localparam logic               False     = 1'b0;

  // Fetch FSM: IDLE looks up the cache, MISS owns the single outstanding request.
  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/icache_fetch_array.sv
// Direct-mapped tag/data/valid storage, one instruction per line.
// Latency: read is combinational from idx; write and flush take effect next cycle.
// Backpressure: none; the caller gates write/flush enables with its global enable.
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int ADDR_W  = AddrLen,
  parameter int INST_W  = InstLen,
  parameter int INDEX_W = DefaultIndexW,
  parameter int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [INST_W-1:0]  rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [INST_W-1:0]  wr_data_i,
  input  logic               flush_i
);

  localparam int Lines = 1 << INDEX_W;

  logic [Lines-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [Lines];
  logic [INST_W-1:0] data_q [Lines];

  // Asynchronous read port.
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Valid-bit update: a flush wins over a same-cycle fill so a stale line never lands.
  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx_i] = True;
    if (flush_i) valid_d = '0;
  end

  // Valid bits are the only storage that needs a reset.
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data payload written on fill; contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// Instruction fetch with direct-mapped I-cache, one outstanding miss, flush and jump-safe refill.
// Latency: hit delivers in the same cycle; a miss delivers on the cycle mem_valid_i returns.
// Backpressure: rdy=0 freezes all state; stall_o holds the PC while a miss is outstanding.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int ADDR_W  = AddrLen,
  parameter int INST_W  = InstLen,
  parameter int INDEX_W = DefaultIndexW,
  parameter int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [INST_W-1:0] mem_inst_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  fetch_state_e      state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [INST_W-1:0]  rd_data;
  logic               hit;

  logic               fill_en;
  logic               hit_evt;
  logic               miss_evt;

  logic               inst_valid_c, stall_c, mem_req_c;
  logic [ADDR_W-1:0]  pc_c, mem_addr_c;
  logic [INST_W-1:0]  inst_c;

  // Byte-offset bits are always zero for a word-aligned PC.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_i[1:0];

  // Full-width tag lookup of the incoming PC.
  assign lk_idx = pc_i[INDEX_W+1:2];
  assign lk_tag = pc_i[ADDR_W-1:INDEX_W+2];
  assign hit    = rd_valid && (rd_tag == lk_tag);

  icache_array #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (lk_idx),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (fill_en),
    .wr_idx_i  (miss_addr_q[INDEX_W+1:2]),
    .wr_tag_i  (miss_addr_q[ADDR_W-1:INDEX_W+2]),
    .wr_data_i (mem_inst_i),
    .flush_i   (flush_i && rdy)
  );

  // Next-state and output decode; all state effects are qualified by rdy.
  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    miss_addr_d  = miss_addr_q;
    fill_en      = False;
    hit_evt      = False;
    miss_evt     = False;
    inst_valid_c = False;
    stall_c      = False;
    mem_req_c    = False;
    pc_c         = '0;
    inst_c       = ZERO_WORD;
    mem_addr_c   = '0;
    case (state_q)
      IDLE: begin
        // A jump discards this fetch entirely; stray mem_valid_i is ignored here.
        if (!jump_i) begin
          if (hit) begin
            inst_valid_c = True;
            pc_c         = pc_i;
            inst_c       = rd_data;
            hit_evt      = rdy;
          end else begin
            stall_c = True;
            if (rdy) begin
              miss_addr_d = pc_i;
              drop_d      = False;
              state_d     = MISS;
              miss_evt    = True;
            end
          end
        end
      end
      MISS: begin
        // The request is never withdrawn; a redirect or flush only suppresses delivery.
        mem_req_c  = True;
        mem_addr_c = miss_addr_q;
        stall_c    = True;
        if (rdy && mem_valid_i) begin
          fill_en = True;
          state_d = IDLE;
          drop_d  = False;
          if (!drop_q && !jump_i) begin
            inst_valid_c = True;
            pc_c         = miss_addr_q;
            inst_c       = mem_inst_i;
            stall_c      = False;
          end
        end else if (rdy && (jump_i || flush_i)) begin
          drop_d = True;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, drop flag and miss address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drop_q      <= False;
      miss_addr_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Every output is forced low while reset is asserted.
  assign inst_valid_o = rst_n && inst_valid_c;
  assign stall_o      = rst_n && stall_c;
  assign mem_req_o    = rst_n && mem_req_c;
  assign pc_o         = rst_n ? pc_c : '0;
  assign inst_o       = rst_n ? inst_c : ZERO_WORD;
  assign mem_addr_o   = rst_n ? mem_addr_c : '0;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Wrapping event counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt)  hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_evt) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Counter registers, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = rst_n ? hit_cnt_q : '0;
  assign miss_cnt_o = rst_n ? miss_cnt_q : '0;
`else
  logic unused_perf;
  assign unused_perf = hit_evt ^ miss_evt;
  assign hit_cnt_o   = '0;
  assign miss_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed vector table, hand sequences, random vs. model.
// Latency: outputs sampled on the falling edge, inputs driven 1 ns after the rising edge.
// Backpressure: the bench plays the memory controller, answering only an outstanding request.
module tb_icache_fetch;

  localparam int XW = 7;

  logic        clk = 1'b0;
  logic        rst_n, rdy, jump_i, flush_i, mem_valid_i;
  logic [31:0] pc_i, mem_inst_i;
  logic [31:0] pc_o, inst_o, mem_addr_o, hit_cnt_o, miss_cnt_o;
  logic        inst_valid_o, stall_o, mem_req_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .pc_i        (pc_i),
    .jump_i      (jump_i),
    .flush_i     (flush_i),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .inst_valid_o(inst_valid_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_valid_i (mem_valid_i),
    .mem_inst_i  (mem_inst_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  typedef struct {
    logic        rst_n, rdy, jump, flush, mv;
    logic [31:0] pc, mi;
    logic        e_vld, e_stall, e_req;
    logic [31:0] e_pc, e_inst, e_addr;
    bit          all0;
  } vec_t;

  vec_t tbl[$];

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic y, input logic [31:0] pc, input logic j,
                       input logic f, input logic mv, input logic [31:0] mi);
    rst_n = r; rdy = y; pc_i = pc; jump_i = j; flush_i = f; mem_valid_i = mv; mem_inst_i = mi;
  endtask

  // Compare outputs on the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string nm, input logic ev, input logic es, input logic er,
                     input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ea,
                     input bit all0);
    @(negedge clk);
    check1({nm, " inst_valid"}, inst_valid_o, ev);
    check1({nm, " stall"}, stall_o, es);
    check1({nm, " mem_req"}, mem_req_o, er);
    if (ev || all0) begin
      check32({nm, " pc_o"}, pc_o, epc);
      check32({nm, " inst_o"}, inst_o, ei);
    end
    if (er || all0) check32({nm, " mem_addr"}, mem_addr_o, ea);
    if (all0 && !rst_n) begin
      check32({nm, " hit_cnt"}, hit_cnt_o, 32'd0);
      check32({nm, " miss_cnt"}, miss_cnt_o, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic j, input logic mv, input logic [31:0] pc,
                              input logic [31:0] mi, input logic ev, input logic es, input logic er,
                              input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ea,
                              input bit all0);
    vec_t v;
    v.rst_n = r; v.rdy = 1'b1; v.jump = j; v.flush = 1'b0; v.mv = mv; v.pc = pc; v.mi = mi;
    v.e_vld = ev; v.e_stall = es; v.e_req = er; v.e_pc = epc; v.e_inst = ei; v.e_addr = ea;
    v.all0 = all0;
    return v;
  endfunction

  // Full miss/refill sequence for one PC, checking each of its three cycles.
  task automatic fill(input string nm, input logic [31:0] pc, input logic [31:0] data);
    drive(1, 1, pc, 0, 0, 0, 0);
    cyc({nm, " miss"}, 0, 1, 0, 0, 0, 0, 0);
    cyc({nm, " req"}, 0, 1, 1, 0, 0, pc, 0);
    drive(1, 1, pc, 0, 0, 1, data);
    cyc({nm, " refill"}, 1, 0, 1, pc, data, pc, 0);
    mem_valid_i = 0;
  endtask

  // Reference model: the cache as a map from word address to instruction,
  // with at most one resident address per index.
  logic [31:0] m_cache [bit [31:0]];
  bit          m_pend, m_drop;
  logic [31:0] m_pc;
  int          m_hits, m_misses;

  function automatic void install(input logic [31:0] a, input logic [31:0] d);
    bit [31:0] victims[$];
    foreach (m_cache[key]) if (key[XW+1:2] == a[XW+1:2]) victims.push_back(key);
    foreach (victims[i]) m_cache.delete(victims[i]);
    m_cache[a] = d;
  endfunction

  logic [31:0] pool [8] = '{32'h0000_0100, 32'h0000_0104, 32'h0002_0100, 32'h0004_0104,
                            32'h0000_1000, 32'h0000_1004, 32'hFFFF_FE00, 32'h8000_0004};

  initial begin
    drive(0, 1, 32'h100, 0, 0, 0, 0);

    // Cold miss, hit, alias replacement, jump suppresses output.
    tbl.push_back(mk(0, 0, 0, 32'h100,   0,            0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h100,   0,            0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h100,   0,            0, 1, 1, 0, 0, 32'h100, 0));
    tbl.push_back(mk(1, 0, 1, 32'h100,   32'h13,       1, 0, 1, 32'h100, 32'h13, 32'h100, 0));
    tbl.push_back(mk(1, 0, 0, 32'h100,   0,            1, 0, 0, 32'h100, 32'h13, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h20100, 0,            0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h20100, 0,            0, 1, 1, 0, 0, 32'h20100, 0));
    tbl.push_back(mk(1, 0, 1, 32'h20100, 32'hAAAA0001, 1, 0, 1, 32'h20100, 32'hAAAA0001, 32'h20100, 0));
    tbl.push_back(mk(1, 0, 0, 32'h100,   0,            0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h100,   0,            0, 1, 1, 0, 0, 32'h100, 0));
    tbl.push_back(mk(1, 0, 1, 32'h100,   32'h13,       1, 0, 1, 32'h100, 32'h13, 32'h100, 0));
    tbl.push_back(mk(1, 0, 0, 32'h100,   0,            1, 0, 0, 32'h100, 32'h13, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h100,   0,            0, 0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].rdy, tbl[i].pc, tbl[i].jump, tbl[i].flush, tbl[i].mv, tbl[i].mi);
      cyc($sformatf("row%0d", i), tbl[i].e_vld, tbl[i].e_stall, tbl[i].e_req,
          tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_addr, tbl[i].all0);
    end
`ifdef ICACHE_PERF_EN
    check32("table hit_cnt", hit_cnt_o, 32'd2);
    check32("table miss_cnt", miss_cnt_o, 32'd3);
`else
    check32("table hit_cnt", hit_cnt_o, 32'd0);
    check32("table miss_cnt", miss_cnt_o, 32'd0);
`endif

    // Jump mid-miss: request stays up, response fills but is not delivered.
    drive(1, 1, 32'h200, 0, 0, 0, 0);
    cyc("jmp miss", 0, 1, 0, 0, 0, 0, 0);
    cyc("jmp m1", 0, 1, 1, 0, 0, 32'h200, 0);
    drive(1, 1, 32'h300, 1, 0, 0, 0);
    cyc("jmp m2", 0, 1, 1, 0, 0, 32'h200, 0);
    jump_i = 0;
    for (int k = 0; k < 3; k++) cyc("jmp wait", 0, 1, 1, 0, 0, 32'h200, 0);
    drive(1, 1, 32'h300, 0, 0, 1, 32'h0BAD_0200);
    cyc("jmp resp", 0, 1, 1, 0, 0, 32'h200, 0);
    drive(1, 1, 32'h200, 0, 0, 0, 0);
    cyc("jmp refetch", 1, 0, 0, 32'h200, 32'h0BAD_0200, 0, 0);

    // Flush invalidates every line; flush beside a fill keeps the line out.
    fill("f400", 32'h400, 32'h4000_0000);
    fill("f404", 32'h404, 32'h4040_0000);
    fill("f408", 32'h408, 32'h4080_0000);
    drive(1, 1, 32'h404, 0, 0, 0, 0);
    cyc("pre-flush hit", 1, 0, 0, 32'h404, 32'h4040_0000, 0, 0);
    drive(1, 1, 32'h400, 1, 1, 0, 0);
    cyc("flush", 0, 0, 0, 0, 0, 0, 1);
    fill("post-flush 400", 32'h400, 32'h4000_0001);
    fill("post-flush 404", 32'h404, 32'h4040_0001);
    fill("post-flush 408", 32'h408, 32'h4080_0001);
    drive(1, 1, 32'h500, 0, 0, 0, 0);
    cyc("f500 miss", 0, 1, 0, 0, 0, 0, 0);
    cyc("f500 req", 0, 1, 1, 0, 0, 32'h500, 0);
    drive(1, 1, 32'h500, 0, 1, 1, 32'h5555);
    cyc("flush+fill", 1, 0, 1, 32'h500, 32'h5555, 32'h500, 0);
    drive(1, 1, 32'h500, 0, 0, 0, 0);
    cyc("not installed", 0, 1, 0, 0, 0, 0, 0);

    // rdy low freezes the miss (a jump during it is ignored); reset mid-miss clears all.
    cyc("rdy req", 0, 1, 1, 0, 0, 32'h500, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 32'h500, (k == 2), 0, 0, 0);
      cyc("rdy0 hold", 0, 1, 1, 0, 0, 32'h500, 0);
    end
    drive(1, 1, 32'h500, 0, 0, 1, 32'h6666);
    cyc("rdy resume", 1, 0, 1, 32'h500, 32'h6666, 32'h500, 0);
    drive(1, 1, 32'h500, 0, 0, 0, 0);
    cyc("rdy hit", 1, 0, 0, 32'h500, 32'h6666, 0, 0);
    drive(1, 0, 32'h700, 0, 0, 0, 0);
    cyc("rdy0 idle", 0, 1, 0, 0, 0, 0, 0);
    cyc("rdy0 idle2", 0, 1, 0, 0, 0, 0, 0);
    rdy = 1;
    cyc("rdy1 miss", 0, 1, 0, 0, 0, 0, 0);
    cyc("rst pre", 0, 1, 1, 0, 0, 32'h700, 0);
    rst_n = 0;
    cyc("rst mid", 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 32'h500, 0, 0, 0, 0);
    cyc("rst invalid", 0, 1, 0, 0, 0, 0, 0);

    // Random traffic against the reference model.
    drive(0, 1, 32'h0, 0, 0, 0, 0);
    cyc("rand rst", 0, 0, 0, 0, 0, 0, 1);
    m_cache.delete();
    m_pend = 0; m_drop = 0; m_pc = 0; m_hits = 0; m_misses = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        r, j, f, mv, ev, es, er;
      logic [31:0] pc, mi, epc, ei, ea;
      pc = pool[$urandom_range(0, 7)];
      r  = ($urandom_range(0, 7) != 0);
      j  = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 19) == 0);
      mi = $urandom;
      mv = 0;
      if (r && m_pend && $urandom_range(0, 2) == 0) mv = 1;
      else if (r && !m_pend && $urandom_range(0, 15) == 0) mv = 1;
      drive(1, r, pc, j, f, mv, mi);

      ev = 0; es = 0; er = 0; epc = 0; ei = 0; ea = 0;
      if (!m_pend) begin
        if (!j) begin
          if (m_cache.exists(pc)) begin
            ev = 1; epc = pc; ei = m_cache[pc];
            if (r) m_hits++;
          end else begin
            es = 1;
            if (r) begin m_pend = 1; m_pc = pc; m_drop = 0; m_misses++; end
          end
        end
      end else begin
        er = 1; ea = m_pc; es = 1;
        if (r && mv) begin
          if (!m_drop && !j) begin ev = 1; epc = m_pc; ei = mi; es = 0; end
          install(m_pc, mi);
          m_pend = 0; m_drop = 0;
        end else if (r && (j || f)) begin
          m_drop = 1;
        end
      end
      if (r && f) m_cache.delete();
      cyc($sformatf("rand%0d", n), ev, es, er, epc, ei, ea, 0);
    end
    @(negedge clk);
`ifdef ICACHE_PERF_EN
    check32("rand hit_cnt", hit_cnt_o, m_hits);
    check32("rand miss_cnt", miss_cnt_o, m_misses);
`else
    check32("rand hit_cnt", hit_cnt_o, 32'd0);
    check32("rand miss_cnt", miss_cnt_o, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
